// File: rtl/auth_pkg.sv
// Shared constants, credential tables and FSM state type
// for the login / high-score responder.
package auth_pkg;

  localparam int NUM_USERS    = 4;
  localparam int IDX_W        = $clog2(NUM_USERS);
  localparam int MAX_ATTEMPTS = 3;
  localparam int ATT_W        = $clog2(MAX_ATTEMPTS + 1);
  localparam int SCORE_W      = 7;
  localparam int DIGITS       = 4;
  localparam int WORD_W       = 4 * DIGITS;
  localparam int CNT_W        = $clog2(DIGITS + 1);

  typedef logic [WORD_W-1:0] bcd_word_t;

  // Word layout is {oldest digit, ..., newest digit}
  localparam bcd_word_t ID_TABLE [NUM_USERS] = '{
    16'h1234, 16'h5678, 16'h1111, 16'h0000
  };

  localparam bcd_word_t PASS_TABLE [NUM_USERS] = '{
    16'h0042, 16'h9999, 16'h2222, 16'h0001
  };

  typedef enum logic [2:0] {
    ID_ENTRY,
    ID_SEARCH,
    PASS_ENTRY,
    PASS_CHECK,
    GRANTED,
    LOCKED
  } auth_state_t;

endpackage

// File: rtl/user_auth_score_store_shifter.sv
// Rising-edge digit loader shared by the ID and password phases:
// edge detect, BCD validity filter, 4-digit shift register, count.
module bcd_digit_shifter
  import auth_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en_id,
  input  logic             i_en_pass,
  input  logic             i_sel_id,
  input  logic             i_sel_pass,
  input  logic [3:0]       i_digit,
  input  logic             i_clr_cnt,
  input  logic             i_clr_dig,
  output bcd_word_t        o_word,
  output logic [CNT_W-1:0] o_cnt
);

  logic             r_id_q;
  logic             r_pass_q;
  bcd_word_t        r_word;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pulse;
  logic             w_load;

  // Both enables are tracked so a phase change never fakes an edge
  assign w_pulse = (i_sel_id & i_en_id & ~r_id_q)
                 | (i_sel_pass & i_en_pass & ~r_pass_q);
  assign w_load  = w_pulse & (i_digit <= 4'd9);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id_q   <= 1'b0;
      r_pass_q <= 1'b0;
      r_word   <= '0;
      r_cnt    <= '0;
    end else begin
      r_id_q   <= i_en_id;
      r_pass_q <= i_en_pass;
      if (i_clr_cnt) begin
        r_cnt <= '0;
        if (i_clr_dig) r_word <= '0;
      end else if (w_load) begin
        r_word <= {r_word[WORD_W-5:0], i_digit};
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  assign o_word = r_word;
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/user_auth_score_store.sv
// Login responder: ID search, password check with lockout,
// and a per-user high-score store.
module user_auth_score_store
  import auth_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enableSetUserIDFlag,
  input  logic               enableSetPassFlag,
  input  logic [3:0]         digitIn,
  input  logic               writeOrRead,
  input  logic [SCORE_W-1:0] maxScore,
  output logic               userIDfoundFlag,
  output logic               accessFlag,
  output logic               blinkFlag,
  output logic               outOfAttemptsFlag,
  output logic [SCORE_W-1:0] RAM_score,
  output logic [3:0]         userID_digit1,
  output logic [3:0]         userID_digit2,
  output logic [3:0]         userID_digit3,
  output logic [3:0]         userID_digit4
);

  auth_state_t        r_state;
  auth_state_t        w_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_user;
  logic [ATT_W-1:0]   r_attempts;
  logic [ATT_W-1:0]   w_att_inc;
  logic               r_found;
  logic               r_access;
  logic               r_blink;
  logic               r_lock;
  logic [SCORE_W-1:0] r_score [NUM_USERS];
  logic [SCORE_W-1:0] r_ram;
  bcd_word_t          r_id;
  bcd_word_t          w_word;
  bcd_word_t          w_shown;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_sel_id;
  logic               w_sel_pass;
  logic               w_clr_cnt;
  logic               w_clr_dig;
  logic               w_match;
  logic               w_pass_ok;
  logic               w_full;

  bcd_digit_shifter u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_en_id    (enableSetUserIDFlag),
    .i_en_pass  (enableSetPassFlag),
    .i_sel_id   (w_sel_id),
    .i_sel_pass (w_sel_pass),
    .i_digit    (digitIn),
    .i_clr_cnt  (w_clr_cnt),
    .i_clr_dig  (w_clr_dig),
    .o_word     (w_word),
    .o_cnt      (w_cnt)
  );

  assign w_full    = (w_cnt == CNT_W'(DIGITS));
  assign w_match   = (w_word == ID_TABLE[r_idx]);
  assign w_pass_ok = (w_word == PASS_TABLE[r_user]);
  assign w_att_inc = r_attempts + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ID_ENTRY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_sel_id   = 1'b0;
    w_sel_pass = 1'b0;
    w_clr_cnt  = 1'b0;
    w_clr_dig  = 1'b0;
    unique case (r_state)
      ID_ENTRY: begin
        if (w_full) w_next = ID_SEARCH;
        else        w_sel_id = 1'b1;
      end
      ID_SEARCH: begin
        if (w_match) begin
          w_clr_cnt = 1'b1;
          w_next    = PASS_ENTRY;
        end else if (r_idx == IDX_W'(NUM_USERS - 1)) begin
          w_clr_cnt = 1'b1;
          w_clr_dig = 1'b1;
          w_next    = ID_ENTRY;
        end
      end
      PASS_ENTRY: begin
        if (w_full) w_next = PASS_CHECK;
        else        w_sel_pass = 1'b1;
      end
      PASS_CHECK: begin
        if (w_pass_ok) begin
          w_next = GRANTED;
        end else begin
          w_clr_cnt = 1'b1;
          if (w_att_inc == ATT_W'(MAX_ATTEMPTS)) w_next = LOCKED;
          else                                  w_next = PASS_ENTRY;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_user     <= '0;
      r_attempts <= '0;
      r_found    <= 1'b0;
      r_access   <= 1'b0;
      r_blink    <= 1'b0;
      r_lock     <= 1'b0;
      r_ram      <= '0;
      r_id       <= '0;
      for (int i = 0; i < NUM_USERS; i++) r_score[i] <= '0;
    end else begin
      r_blink <= 1'b0;
      if (r_state == ID_ENTRY) r_idx <= '0;
      if (r_state == ID_SEARCH) begin
        if (w_match) begin
          r_user  <= r_idx;
          r_found <= 1'b1;
          r_id    <= w_word;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      if (r_state == PASS_CHECK) begin
        if (w_pass_ok) begin
          r_access <= 1'b1;
        end else begin
          r_blink    <= 1'b1;
          r_attempts <= w_att_inc;
          if (w_att_inc == ATT_W'(MAX_ATTEMPTS)) r_lock <= 1'b1;
        end
      end
      if (r_state == GRANTED && writeOrRead
          && maxScore > r_score[r_user])
        r_score[r_user] <= maxScore;
      r_ram <= r_found ? r_score[r_user] : '0;
    end
  end

  // Once an ID is matched the shifter carries password digits
  assign w_shown = (r_state == ID_ENTRY || r_state == ID_SEARCH)
                 ? w_word : r_id;

  assign userIDfoundFlag   = r_found;
  assign accessFlag        = r_access;
  assign blinkFlag         = r_blink;
  assign outOfAttemptsFlag = r_lock;
  assign RAM_score         = r_ram;
  assign userID_digit1     = w_shown[3:0];
  assign userID_digit2     = w_shown[7:4];
  assign userID_digit3     = w_shown[11:8];
  assign userID_digit4     = w_shown[15:12];

endmodule
